// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment serial shift driver.
package seg_pkg;

  localparam int SEG_SEGS_DEFAULT = 7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } seg_state_t;

  // Serial bits per lane for a frame split evenly across the chains.
  function automatic int seg_bits(input int digits, input int segs, input int lanes);
    return (digits * segs) / lanes;
  endfunction

endpackage

// File: rtl/seg_shift_driver_sclk_tick.sv
// Half-period phase counter: one-cycle tick at the end of every SCLK_DIV-cycle phase.
module sclk_tick #(
  parameter int SCLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(SCLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_shift_driver.sv
// Serialises a packed seven-segment frame onto LANES 74HC595-style chains with retrigger coalescing.
// Build option SEG_SHIFT_DRIVER_ACTIVE_LOW_EN inverts every shifted segment bit (common-anode).
//
// state    | meaning
// IDLE     | outputs quiet; launches from start_i or a pending shadow frame
// SHIFT_LO | sclk_o low, current bit presented on data_o
// SHIFT_HI | sclk_o high, chain samples data_o
// LATCH    | latch_o high, storage registers update
module seg_shift_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int SEGS     = SEG_SEGS_DEFAULT,
  parameter int LANES    = 1,
  parameter int SCLK_DIV = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DIGITS*SEGS-1:0] data_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   sclk_o,
  output logic [LANES-1:0]       data_o,
  output logic                   latch_o
);

  localparam int W    = DIGITS * SEGS;
  localparam int BITS = seg_bits(DIGITS, SEGS, LANES);
  localparam int CNTW = $clog2(BITS + 1);

`ifdef SEG_SHIFT_DRIVER_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  if ((DIGITS % LANES) != 0) begin : g_bad_lanes
    $error("seg_shift_driver: DIGITS must be a multiple of LANES");
  end
  if (SCLK_DIV < 1) begin : g_bad_div
    $error("seg_shift_driver: SCLK_DIV must be at least 1");
  end

  seg_state_t      state_q, state_d;
  logic [W-1:0]    sreg_q, sreg_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            done_q, done_d;
  logic            tick, tick_clr, capture, launch;

  sclk_tick #(.SCLK_DIV(SCLK_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    launch    = 1'b0;
    // The done cycle is treated as still busy so a start there queues behind it.
    capture   = start_i && ((state_q != IDLE) || done_q || pending_q);
    if (capture) begin
      shadow_d  = data_i;
      pending_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          sreg_d    = shadow_q;
          pending_d = capture;
          launch    = 1'b1;
        end else if (start_i && !done_q) begin
          sreg_d = data_i;
          launch = 1'b1;
        end
      end
      SHIFT_LO: if (tick) state_d = SHIFT_HI;
      SHIFT_HI: begin
        if (tick) begin
          sreg_d  = sreg_q << 1;
          cnt_d   = cnt_q - CNTW'(1);
          state_d = (cnt_q == CNTW'(1)) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = SHIFT_LO;
      cnt_d   = CNTW'(BITS);
    end
    tick_clr = launch;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign sclk_o  = (state_q == SHIFT_HI);
  assign latch_o = (state_q == LATCH);

  // Lane k's current bit is the MSB of its BITS-wide slice; digit 0 sits in lane 0.
  always_comb begin
    data_o = '0;
    if ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) begin
      for (int k = 0; k < LANES; k++) data_o[k] = sreg_q[W-1-k*BITS] ^ INV;
    end
  end

endmodule

// File: tb/tb_seg_shift_driver.sv
// Randomised self-checking bench: default driver plus a 2-lane, SCLK_DIV=3 instance.
module tb_seg_shift_driver;

`ifdef SEG_SHIFT_DRIVER_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [41:0] data = '0;

  logic a_busy, a_done, a_sclk, a_latch;
  logic [0:0] a_data;
  logic b_busy, b_done, b_sclk, b_latch;
  logic [1:0] b_data;
  logic [5:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_shift_driver u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start & ~sel), .data_i(data),
    .busy_o(a_busy), .done_o(a_done), .sclk_o(a_sclk), .data_o(a_data), .latch_o(a_latch)
  );

  seg_shift_driver #(.DIGITS(6), .LANES(2), .SCLK_DIV(3)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start & sel), .data_i(data),
    .busy_o(b_busy), .done_o(b_done), .sclk_o(b_sclk), .data_o(b_data), .latch_o(b_latch)
  );

  assign obs = sel ? {b_busy, b_done, b_sclk, b_latch, b_data}
                   : {a_busy, a_done, a_sclk, a_latch, 1'b0, a_data};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected {busy,done,sclk,latch,data[1:0]} at cycle c after the start edge.
  function automatic logic [5:0] exp_vec(input logic [41:0] frame, input int c);
    int lanes, s, bits, len, b;
    logic hi;
    logic [1:0] d;
    lanes = sel ? 2 : 1;
    s     = sel ? 3 : 1;
    bits  = 42 / lanes;
    len   = 2 * s * bits;
    d     = '0;
    if (c < len) begin
      b  = c / (2 * s);
      hi = (c % (2 * s)) >= s;
      for (int k = 0; k < lanes; k++) d[k] = frame[41 - k*bits - b] ^ INV;
      return {1'b1, 1'b0, hi, 1'b0, d};
    end else if (c < len + s) begin
      return 6'b100100;
    end
    return 6'b010000;
  endfunction

  function automatic int xfer_len();
    return sel ? (2*3*21 + 3) : (2*1*42 + 1);
  endfunction

  // Called in the first busy cycle; returns positioned in the done cycle.
  task automatic check_xfer(input logic [41:0] frame, input string tag);
    for (int c = 0; c <= xfer_len(); c++) begin
      check_val($sformatf("%s c%0d", tag, c), 32'(obs), 32'(exp_vec(frame, c)));
      if (c != xfer_len()) tick_n(1);
    end
  endtask

  task automatic start_pulse(input logic [41:0] frame);
    data  = frame;
    start = 1'b1;
    tick_n(1);
    start = 1'b0;
  endtask

  logic [63:0]  r;
  logic [41:0]  fa, fb, fc;

  initial begin
    tick_n(3);
    sel = 1'b0; check_val("reset_a", 32'(obs), 32'h0);
    sel = 1'b1; check_val("reset_b", 32'(obs), 32'h0);
    rst = 1'b0;
    sel = 1'b0;
    tick_n(2);

    start_pulse(42'h2AA_AAAA_AAAA);
    check_xfer(42'h2AA_AAAA_AAAA, "alt_pattern");
    tick_n(1);
    check_val("idle_after_alt", 32'(obs), 32'h0);

    for (int i = 0; i < 8; i++) begin
      sel = i[0];
      r = {$urandom, $urandom};
      fa = (i < 2) ? '0 : (i < 4) ? '1 : r[41:0];
      start_pulse(fa);
      check_xfer(fa, $sformatf("rand%0d", i));
      tick_n(1);
      check_val("idle_after_rand", 32'(obs), 32'h0);
      tick_n($urandom_range(0, 3));
    end

    // Two retriggers during a transfer: only the latest frame follows.
    sel = 1'b0;
    r = {$urandom, $urandom}; fa = r[41:0];
    r = {$urandom, $urandom}; fb = r[41:0];
    r = {$urandom, $urandom}; fc = r[41:0];
    start_pulse(fa);
    fork
      check_xfer(fa, "coalesce_cur");
      begin
        tick_n(10);
        data = fb; start = 1'b1; tick_n(1); start = 1'b0;
        tick_n(20);
        data = fc; start = 1'b1; tick_n(1); start = 1'b0;
      end
    join
    tick_n(1);
    check_xfer(fc, "coalesce_next");
    for (int i = 0; i < 100; i++) begin
      tick_n(1);
      check_val("no_third_xfer", 32'(obs), 32'h0);
    end

    // Reset at bit 10 aborts silently; start held during reset is ignored.
    r = {$urandom, $urandom}; fa = r[41:0];
    start_pulse(fa);
    tick_n(20);
    check_val("pre_abort_busy", 32'(obs[5]), 32'h1);
    rst = 1'b1;
    start = 1'b1;
    tick_n(1);
    check_val("abort_outputs", 32'(obs), 32'h0);
    tick_n(1);
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick_n(1);
      check_val("post_abort_quiet", 32'(obs), 32'h0);
    end
    r = {$urandom, $urandom}; fa = r[41:0];
    start_pulse(fa);
    check_xfer(fa, "post_abort_fresh");

    // Start in the final latch cycle, then start on the done cycle (2-lane instance).
    tick_n(3);
    sel = 1'b1;
    r = {$urandom, $urandom}; fa = r[41:0];
    r = {$urandom, $urandom}; fb = r[41:0];
    r = {$urandom, $urandom}; fc = r[41:0];
    start_pulse(fa);
    fork
      check_xfer(fa, "latch_start_cur");
      begin
        tick_n(128);
        data = fb; start = 1'b1; tick_n(1); start = 1'b0;
      end
    join
    tick_n(1);
    check_xfer(fb, "latch_start_next");
    data = fc; start = 1'b1;
    tick_n(1);
    start = 1'b0;
    check_val("done_start_gap", 32'(obs), 32'h0);
    tick_n(1);
    check_xfer(fc, "done_start_next");
    tick_n(1);
    check_val("final_idle", 32'(obs), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_shift_driver.md
# seg_shift_driver

Parametrised successor to the single-chain seven-segment shift-register output stage of the MSF clock. It serialises a packed seven-segment frame onto one or more parallel 74HC595-style chains with a programmable serial-clock rate, a start/busy/done handshake and coalescing of retriggers. It sits between `seven_seg_digits` and the chip pins, started by the delayed `second_inc` pulse.

## Interface
Parameters:
- `DIGITS`, 6, digits in the frame; must be a multiple of `LANES`.
- `SEGS`, 7, segment bits per digit.
- `LANES`, 1, parallel serial data outputs sharing one `sclk_o`/`latch_o`.
- `SCLK_DIV`, 1, `clk_i` cycles per `sclk_o` half-period; must be ≥ 1.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: request transfer of `data_i`; single-cycle pulse or level.
- `data_i` in `DIGITS*SEGS`: frame; digit 0 in the MSBs.
- `busy_o` out 1: a transfer is in progress.
- `done_o` out 1: one-cycle pulse on completion of a transfer.
- `sclk_o` out 1: shift clock; data is stable on the rising edge.
- `data_o` out `LANES`: serial data, one bit per chain.
- `latch_o` out 1: storage-register clock.

## Operation
- `BITS = DIGITS*SEGS/LANES`.
  - Lane k carries digits `k*DIGITS/LANES` .. `(k+1)*DIGITS/LANES-1`.
  - Each lane shifts MSB first.
- States:
  - IDLE → SHIFT_LO on `start_i`. Capture `data_i` into the shift register and load the bit counter with `BITS`.
  - SHIFT_LO (`sclk_o`=0, `data_o` shows the current bit) → SHIFT_HI after `SCLK_DIV` cycles.
  - SHIFT_HI (`sclk_o`=1) → SHIFT_LO after `SCLK_DIV` cycles.
    - On leaving SHIFT_HI, shift left and decrement the counter.
    - If the counter reaches 0, go to LATCH instead.
  - LATCH (`latch_o`=1, `sclk_o`=0, `data_o`=0) → IDLE after `SCLK_DIV` cycles.
- Retrigger:
  - `start_i` while `busy_o`=1 copies `data_i` into a shadow register and sets `pending`.
  - A later start overwrites the shadow; the latest frame wins.
  - The active transfer is never disturbed.
- On entering IDLE with `pending` set:
  - Assert `done_o`.
  - Next cycle, start a new transfer from the shadow and clear `pending`.
- `start_i` in the same cycle as the transition to IDLE counts as a pending request.
- Illegal parameters (`DIGITS % LANES != 0`, `SCLK_DIV < 1`) cause an elaboration-time error.

## Timing
- Reset:
  - All outputs go to 0 on the next edge.
  - `pending`, the shadow and the shift register are cleared.
  - Reset mid-transfer aborts with no latch pulse and no `done_o`.
  - `start_i` during `rst_i` is ignored.
- `start_i` sampled at edge t:
  - From t+1: `busy_o`=1 and the first bit is on `data_o`.
  - Each bit is held for `2*SCLK_DIV` cycles; `sclk_o` is low for the first half and high for the second.
- The latch pulse occupies `SCLK_DIV` cycles starting at t+1+`2*SCLK_DIV*BITS`.
- `done_o`=1 and `busy_o`=0 at t+1+`2*SCLK_DIV*BITS`+`SCLK_DIV`.
- Defaults (`BITS`=42, `SCLK_DIV`=1): `done_o` at t+86.
- A pending rerun leaves exactly one cycle with `busy_o`=0 (the `done_o` cycle) before the next first bit.

## Configuration
- `SEG_SHIFT_DRIVER_ACTIVE_LOW_EN`
  - Defined: every shifted segment bit is inverted on `data_o` (common-anode displays).
  - Undefined: bits are shifted as given.
  - In both builds `data_o` is 0 in IDLE, LATCH and reset; timing is identical.

## Structure
- Package `seg_pkg` holds:
  - the `SEGS` default constant;
  - the `seg_state_t` enum (IDLE, SHIFT_LO, SHIFT_HI, LATCH);
  - the helper function computing `BITS`.
- Sub-module `sclk_tick`: a `SCLK_DIV` phase counter that emits a one-cycle tick at the end of each half-period. It is cleared on `rst_i` and on transfer start.
- The FSM, bit counter, shift register, shadow and pending flag live in the top of the block.

## Test plan
- Defaults, `data_i`=42'h2AA_AAAA_AAAA, one start → 42 rising `sclk_o` edges carrying 1,0,1,0…; one latch cycle; `done_o` at t+86.
- `LANES`=2, `DIGITS`=6, `SCLK_DIV`=3 → each lane emits 21 bits matching its digit slice; each `sclk_o` half-period is 3 cycles; `done_o` at t+1+126+3.
- Two starts during a transfer with frames A then B → the current frame completes untouched; only B is sent next, after a single idle cycle; `done_o` pulses twice in total.
- `rst_i` asserted at bit 10 → outputs 0 next cycle; no latch pulse, no `done_o`; a start after reset is a fresh full transfer.
- `start_i` exactly on the `done_o` cycle → treated as pending; the new transfer's first bit appears 2 cycles later.
- Build with `SEG_SHIFT_DRIVER_ACTIVE_LOW_EN`, frame all zeros → `data_o`=1 during every SHIFT state and 0 in IDLE and LATCH.
